// File: rtl/pcs_pkg.sv
// pcs_pkg: shared PCS constants, sync headers and the deskew state encoding.
package pcs_pkg;
  localparam int LANE_N = 4;
  localparam int BLOCK_W = 66;
  localparam int MAX_SKEW_BIT_N = 1856;
  localparam int MAX_SKEW_BLOCK_N = (MAX_SKEW_BIT_N - BLOCK_W - 1) / BLOCK_W;
  localparam int CNT_W = $clog2(MAX_SKEW_BLOCK_N + 1);
  localparam logic [1:0] SH_CTRL = 2'b10;
  localparam logic [1:0] SH_DATA = 2'b01;
  typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_ALIGNED} deskew_state_e;
endpackage

// File: rtl/deskew_lane_delay.sv
// deskew_lane_delay: per-lane block delay line with a selectable output tap.
module deskew_lane_delay #(
  parameter int W = 66,
  parameter int DEPTH = 27,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [W-1:0]     i_data,
  input  logic [CNT_W-1:0] i_dly,
  output logic [W-1:0]     o_data
);
  logic [W-1:0] r_sr [0:DEPTH];
  always_ff @(posedge clk)
    if (rst) r_sr <= '{default: '0};
    else if (i_valid) begin
      r_sr[0] <= i_data;
      for (int k = 1; k <= DEPTH; k++) r_sr[k] <= r_sr[k-1];
    end
  assign o_data = r_sr[i_dly];
endmodule

// File: rtl/pcs_deskew_rx.sv
// pcs_deskew_rx: measures inter-lane marker skew and delays each lane so
// all alignment markers leave on data_o in the same cycle.
module pcs_deskew_rx
  import pcs_pkg::*;
(
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [LANE_N-1:0]         valid_i,
  input  logic [LANE_N-1:0]         am_lite_v_i,
  input  logic [LANE_N-1:0]         am_lite_lock_v_i,
  input  logic [LANE_N-1:0]         am_lite_lock_lost_v_i,
  input  logic [LANE_N*BLOCK_W-1:0] data_i,
  output logic [LANE_N*BLOCK_W-1:0] data_o
);
  deskew_state_e r_state, w_state_nxt;
  logic [LANE_N-1:0][CNT_W-1:0] r_dly, w_dly_nxt;
  logic [LANE_N-1:0] r_seen, w_seen_nxt, w_cap, w_ovf;
  logic w_search, w_lost;
  assign w_search = r_state != ST_ALIGNED;
  assign w_lost = |am_lite_lock_lost_v_i | (~w_search & ~&am_lite_lock_v_i);
  assign w_cap = am_lite_v_i & valid_i & ~r_seen & {LANE_N{w_search}};
  always_ff @(posedge clk)
    if (nreset) begin
      r_state <= ST_IDLE;
      r_seen <= '0;
      r_dly <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_seen <= w_seen_nxt;
      r_dly <= w_dly_nxt;
    end
  // Seen lanes age by one per valid block until the last lane captures.
  always_comb begin
    w_ovf = '0;
    w_seen_nxt = r_seen | w_cap;
    w_dly_nxt = r_dly;
    for (int i = 0; i < LANE_N; i++) begin
      w_ovf[i] = r_seen[i] & valid_i[i] & (r_dly[i] == CNT_W'(MAX_SKEW_BLOCK_N));
      w_dly_nxt[i] = w_cap[i] ? '0 : (r_seen[i] & valid_i[i]) ? r_dly[i] + 1'b1 : r_dly[i];
    end
    w_state_nxt = &w_seen_nxt ? ST_ALIGNED : |w_seen_nxt ? ST_SEARCH : ST_IDLE;
    if (w_lost || (w_search && |w_ovf)) begin
      w_seen_nxt = '0;
      w_dly_nxt = '0;
      w_state_nxt = ST_IDLE;
    end else if (!w_search) begin
      w_seen_nxt = r_seen;
      w_dly_nxt = r_dly;
      w_state_nxt = ST_ALIGNED;
    end
  end
  for (genvar g = 0; g < LANE_N; g++) begin : g_lane
    deskew_lane_delay #(.W(BLOCK_W), .DEPTH(MAX_SKEW_BLOCK_N), .CNT_W(CNT_W)) u_dly (
      .clk(clk),
      .rst(nreset),
      .i_valid(valid_i[g]),
      .i_data(data_i[g*BLOCK_W +: BLOCK_W]),
      .i_dly(r_dly[g]),
      .o_data(data_o[g*BLOCK_W +: BLOCK_W])
    );
  end
endmodule

// File: tb/tb_pcs_deskew_rx.sv
// tb_pcs_deskew_rx: directed skew scenarios plus random traffic against a
// history-queue reference model of the deskewer.
module tb_pcs_deskew_rx;
  import pcs_pkg::*;
  localparam int L = LANE_N;
  localparam int W = BLOCK_W;
  localparam int M = MAX_SKEW_BLOCK_N;
  logic clk = 1'b0;
  logic nreset;
  logic [L-1:0] valid_i, am, lock, lost;
  logic [L*W-1:0] data_i, data_o;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] mk [L];
  logic [W-1:0] hist [L][$];
  int tot [L], cap [L], fdly [L];
  bit seen [L];
  bit aligned;

  always #5 clk = ~clk;

  pcs_deskew_rx dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .am_lite_v_i(am),
    .am_lite_lock_v_i(lock), .am_lite_lock_lost_v_i(lost),
    .data_i(data_i), .data_o(data_o)
  );

  function automatic logic [W-1:0] rnd();
    return W'({$urandom, $urandom, $urandom});
  endfunction

  function automatic int exp_dly(int i);
    return aligned ? fdly[i] : seen[i] ? tot[i] - cap[i] : 0;
  endfunction

  function automatic logic [L*W-1:0] exp_out();
    logic [L*W-1:0] r = '0;
    for (int i = 0; i < L; i++) begin
      int d = exp_dly(i);
      if (d < hist[i].size()) r[i*W +: W] = hist[i][d];
    end
    return r;
  endfunction

  function automatic logic [L*CNT_W-1:0] exp_dlyv();
    logic [L*CNT_W-1:0] r = '0;
    for (int i = 0; i < L; i++) r[i*CNT_W +: CNT_W] = CNT_W'(exp_dly(i));
    return r;
  endfunction

  function automatic logic [1:0] exp_state();
    bit any = 0;
    for (int i = 0; i < L; i++) any |= seen[i];
    return aligned ? ST_ALIGNED : any ? ST_SEARCH : ST_IDLE;
  endfunction

  // Reference: each lane keeps its accepted-block history; a lane's delay is
  // the number of its blocks accepted since its marker.
  task automatic model_edge();
    bit lost_now, ovf, all;
    if (nreset) begin
      for (int i = 0; i < L; i++) begin
        hist[i].delete();
        tot[i] = 0; seen[i] = 0; fdly[i] = 0;
      end
      aligned = 0;
      return;
    end
    lost_now = (|lost) || (aligned && !(&lock));
    for (int i = 0; i < L; i++)
      if (valid_i[i]) begin
        hist[i].push_front(data_i[i*W +: W]);
        tot[i]++;
        if (hist[i].size() > 40) void'(hist[i].pop_back());
      end
    if (lost_now) begin
      for (int i = 0; i < L; i++) begin seen[i] = 0; fdly[i] = 0; end
      aligned = 0;
    end else if (!aligned) begin
      for (int i = 0; i < L; i++)
        if (am[i] && valid_i[i] && !seen[i]) begin seen[i] = 1; cap[i] = tot[i]; end
      ovf = 0; all = 1;
      for (int i = 0; i < L; i++) begin
        if (seen[i] && tot[i] - cap[i] > M) ovf = 1;
        all &= seen[i];
      end
      if (ovf) for (int i = 0; i < L; i++) seen[i] = 0;
      else if (all) begin
        aligned = 1;
        for (int i = 0; i < L; i++) fdly[i] = tot[i] - cap[i];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [L*W-1:0] got, input logic [L*W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("data_o", data_o, exp_out());
    chk("state", dut.r_state, exp_state());
    chk("dly", dut.r_dly, exp_dlyv());
  endtask

  task automatic cyc(input logic [L-1:0] am_m, input logic [L-1:0] lost_m);
    valid_i = '1; lock = '1; am = am_m; lost = lost_m;
    for (int i = 0; i < L; i++) data_i[i*W +: W] = am_m[i] ? mk[i] : rnd();
    tick();
  endtask

  task automatic seq(input int t0, input int t1, input int t2, input int t3, input string tag);
    int t [L];
    int mx;
    logic [L-1:0] m;
    logic [L*CNT_W-1:0] ed;
    t = '{t0, t1, t2, t3};
    mx = 0;
    for (int i = 0; i < L; i++) if (t[i] > mx) mx = t[i];
    for (int c = 0; c <= mx; c++) begin
      for (int i = 0; i < L; i++) m[i] = (t[i] == c);
      cyc(m, '0);
    end
    for (int i = 0; i < L; i++) ed[i*CNT_W +: CNT_W] = CNT_W'(mx - t[i]);
    chk({tag, "_markers"}, data_o, {mk[3], mk[2], mk[1], mk[0]});
    chk({tag, "_dly"}, dut.r_dly, ed);
    chk({tag, "_aligned"}, dut.r_state, ST_ALIGNED);
  endtask

  initial begin
    mk[0] = {SH_CTRL, 56'h00b8896f004776, 8'h90};
    mk[1] = {SH_CTRL, 56'h00f0c4e60f3b19, 8'hf0};
    mk[2] = {SH_CTRL, 56'h00c5659b3a9a64, 8'hc5};
    mk[3] = {SH_CTRL, 56'h00a2793d5d86c2, 8'ha2};
    nreset = 1'b1; valid_i = '0; am = '0; lock = '0; lost = '0; data_i = '0;
    tick();
    tick();
    chk("reset_data", data_o, '0);
    nreset = 1'b0;
    repeat (3) cyc('0, '0);
    seq(0, 3, 1, 4, "skew0314");
    repeat (3) cyc(4'b1111, '0);
    cyc('0, 4'b1000);
    cyc(4'b1111, '0);
    chk("zero_skew_markers", data_o, {mk[3], mk[2], mk[1], mk[0]});
    chk("zero_skew_dly", dut.r_dly, '0);
    cyc('0, 4'b0100);
    chk("lost_state", dut.r_state, ST_IDLE);
    chk("lost_dly", dut.r_dly, '0);
    seq(2, 0, 2, 1, "skew2021");
    cyc('0, 4'b0001);
    cyc(4'b0111, '0);
    cyc(4'b0111, '0);
    cyc(4'b1000, 4'b0010);
    chk("lost_prio_state", dut.r_state, ST_IDLE);
    chk("lost_prio_dly", dut.r_dly, '0);
    seq(1, 0, 3, 2, "skew1032");
    cyc('0, 4'b0001);
    cyc(4'b0111, '0);
    repeat (M) cyc('0, '0);
    chk("ovf_edge_state", dut.r_state, ST_SEARCH);
    chk("ovf_edge_dly", dut.r_dly, {CNT_W'(0), CNT_W'(M), CNT_W'(M), CNT_W'(M)});
    cyc('0, '0);
    chk("ovf_state", dut.r_state, ST_IDLE);
    chk("ovf_dly", dut.r_dly, '0);
    cyc('0, '0);
    chk("ovf_passthru", data_o, data_i);
    cyc(4'b0001, '0);
    cyc('0, '0);
    nreset = 1'b1;
    tick();
    nreset = 1'b0;
    chk("midreset_data", data_o, '0);
    chk("midreset_state", dut.r_state, ST_IDLE);
    chk("midreset_dly", dut.r_dly, '0);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < L; i++) begin
        valid_i[i] = ($urandom_range(0, 9) != 0);
        am[i] = ($urandom_range(0, 7) == 0);
        lock[i] = ($urandom_range(0, 39) != 0);
        data_i[i*W +: W] = am[i] ? mk[i] : rnd();
      end
      lost = ($urandom_range(0, 31) == 0) ? L'(1 << $urandom_range(0, L-1)) : '0;
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
